// File: rtl/i2c_target.sv
// I2C target responder for one 7-bit address: filtered SCL/SDA, START/STOP detect, write strobe, read handshake.
// Optional clock stretching on read underrun when I2C_TARGET_STRETCH_EN is defined.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         FILTER_LEN  = 3,
    parameter int         HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_full,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       rd_underrun
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    state_t state, state_n;

    // index 0 = SCL, 1 = SDA
    logic [1:0]      s1, s2, filt, filt_d;
    logic [1:0][3:0] fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 2'b11;
            s2     <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            fcnt   <= '0;
        end else begin
            s1     <= {sda_i, scl_i};
            s2     <= s1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != filt[i]) begin
                    if (fcnt[i] == 4'(FILTER_LEN - 1)) begin
                        filt[i] <= s2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    logic scl_f, sda_f, start, stop, rise, fall;
    assign scl_f = filt[0];
    assign sda_f = filt[1];
    assign start = ~sda_f & filt_d[1] & scl_f;
    assign stop  = sda_f & ~filt_d[1] & scl_f;
    // bus conditions win over a coincident SCL edge
    assign rise  = scl_f & ~filt_d[0] & ~start & ~stop;
    assign fall  = ~scl_f & filt_d[0] & ~start & ~stop;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rw, ack_ok, have_byte, hs, match, hold_fire, ack_oe;
    logic [HW-1:0] hold_cnt;
    logic          sda_oe_r, busy_r, rd_req_r, wr_valid_r, rd_underrun_r;
    logic [7:0]    wr_data_r;

    assign hs        = rd_req_r & rd_valid;
    assign match     = (shift[6:0] == ADDR) && (ADDR != 7'h00);
    assign hold_fire = (HOLD_CYCLES == 1) ? fall : (hold_cnt == HW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start) state_n = S_ADDR;
        else if (stop) state_n = S_IDLE;
        else if (rise) begin
            case (state)
                S_ADDR:      if (bit_cnt == 3'd7) state_n = match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  state_n = rw ? S_READ : S_WRITE;
                S_WRITE:     if (bit_cnt == 3'd7) state_n = S_WRITE_ACK;
                S_WRITE_ACK: state_n = S_WRITE;
                S_READ:      if (bit_cnt == 3'd7) state_n = S_READ_ACK;
                S_READ_ACK:  state_n = sda_f ? S_IGNORE : S_READ;
                default:     state_n = state;
            endcase
        end
    end

    always_comb begin
        ack_oe = 1'b0;
        case (state)
            S_ADDR_ACK:  ack_oe = 1'b1;
            S_WRITE_ACK: ack_oe = ack_ok;
            default:     ack_oe = 1'b0;
        endcase
    end

`ifdef I2C_TARGET_STRETCH_EN
    logic          scl_oe_r, stretching;
    logic [HW-1:0] rel_cnt;
    assign scl_oe = scl_oe_r;
`else
    assign scl_oe = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt       <= '0;
            shift         <= 8'hFF;
            rw            <= 1'b0;
            ack_ok        <= 1'b0;
            have_byte     <= 1'b0;
            hold_cnt      <= '0;
            sda_oe_r      <= 1'b0;
            busy_r        <= 1'b0;
            rd_req_r      <= 1'b0;
            wr_data_r     <= '0;
            wr_valid_r    <= 1'b0;
            rd_underrun_r <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_oe_r      <= 1'b0;
            stretching    <= 1'b0;
            rel_cnt       <= '0;
`endif
        end else begin
            wr_valid_r    <= 1'b0;
            rd_underrun_r <= 1'b0;
            if (start || stop) begin
                sda_oe_r  <= 1'b0;
                rd_req_r  <= 1'b0;
                busy_r    <= 1'b0;
                have_byte <= 1'b0;
                hold_cnt  <= '0;
`ifdef I2C_TARGET_STRETCH_EN
                scl_oe_r   <= 1'b0;
                stretching <= 1'b0;
                rel_cnt    <= '0;
`endif
                if (start) begin
                    bit_cnt <= '0;
                    shift   <= '0;
                end
            end else begin
                if (fall) hold_cnt <= HW'(HOLD_CYCLES - 1);
                else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
                if (rel_cnt != '0) begin
                    rel_cnt <= rel_cnt - 1'b1;
                    if (rel_cnt == HW'(1)) scl_oe_r <= 1'b0;
                end
`endif
                if (rise) begin
                    case (state)
                        S_ADDR: begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7 && match) begin
                                busy_r <= 1'b1;
                                rw     <= sda_f;
                            end
                        end
                        S_WRITE: begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_data_r  <= {shift[6:0], sda_f};
                                wr_valid_r <= ~wr_full;
                                ack_ok     <= ~wr_full;
                            end
                        end
                        S_READ: begin
                            shift   <= {shift[6:0], 1'b1};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        S_READ_ACK: begin
                            if (!sda_f) rd_req_r <= 1'b1;
                            else        busy_r   <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                // only the fall that opens a read byte ever sees bit_cnt == 0 in READ
                if (fall && state == S_READ && bit_cnt == 3'd0 && !have_byte && !hs)
                    rd_req_r <= 1'b1;
                if (hs) begin
                    rd_req_r <= 1'b0;
                    shift    <= rd_data;
`ifdef I2C_TARGET_STRETCH_EN
                    if (stretching) begin
                        sda_oe_r   <= ~rd_data[7];
                        stretching <= 1'b0;
                        rel_cnt    <= HW'(HOLD_CYCLES);
                    end else begin
                        have_byte <= 1'b1;
                    end
`else
                    have_byte <= 1'b1;
`endif
                end
                if (hold_fire) begin
                    if (state == S_READ) begin
                        if (bit_cnt != 3'd0 || have_byte) begin
                            sda_oe_r  <= ~shift[7];
                            have_byte <= 1'b0;
                        end else if (hs) begin
                            sda_oe_r  <= ~rd_data[7];
                            have_byte <= 1'b0;
                        end else begin
`ifdef I2C_TARGET_STRETCH_EN
                            scl_oe_r   <= 1'b1;
                            stretching <= 1'b1;
`else
                            sda_oe_r      <= 1'b0;
                            shift         <= 8'hFF;
                            rd_req_r      <= 1'b0;
                            rd_underrun_r <= 1'b1;
`endif
                        end
                    end else begin
                        sda_oe_r <= ack_oe;
                    end
                end
            end
        end
    end

    assign sda_oe      = sda_oe_r;
    assign busy        = busy_r;
    assign rd_req      = rd_req_r;
    assign wr_data     = wr_data_r;
    assign wr_valid    = wr_valid_r;
    assign rd_underrun = rd_underrun_r;
endmodule
